// File: rtl/regfile_decoder_pipe.sv
// regfile_decoder_pipe
// Register-file address decoder with one pipeline stage. Turns per-port
// read ids and a write id into registered one-hot wordlines, flags
// write-to-read bypass per read port and keeps a saturating 8-bit count
// of bypass events.
//
// Optional build macro: ZERO_REG_EN
//   defined   : register 0 is hardwired zero. A write to id 0 is dropped
//               (wr_wl = 0, wr_drop = 1), never bypasses, and a read of
//               id 0 raises rd_zero for that port.
//   undefined : register 0 is ordinary; rd_zero and wr_drop stay 0.
//
// Parameters
//   ADDR_W  register-id width, N = 2**ADDR_W entries
//   NUM_RD  number of read ports
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset, clears every output
//   stall    holds all output registers (cnt_clr still acts)
//   rd_en    per-port read enable
//   rd_id    read ids, port i at [i*ADDR_W +: ADDR_W]
//   wr_en    write enable
//   wr_id    write id
//   cnt_clr  clears hz_cnt, overriding stall and increment
//   rd_wl    one-hot read wordlines, port i at [i*N +: N]
//   wr_wl    one-hot write wordline
//   byp      per-port write-to-read bypass flag
//   rd_zero  per-port read of register 0 (ZERO_REG_EN only)
//   wr_drop  write suppressed (ZERO_REG_EN only)
//   hz_cnt   saturating count of bypass events
module regfile_decoder_pipe #(
  parameter  int ADDR_W = 4,
  parameter  int NUM_RD = 2,
  localparam int N      = 2 ** ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_id,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_id,
  input  logic                     cnt_clr,
  output logic [NUM_RD*N-1:0]      rd_wl,
  output logic [N-1:0]             wr_wl,
  output logic [NUM_RD-1:0]        byp,
  output logic [NUM_RD-1:0]        rd_zero,
  output logic                     wr_drop,
  output logic [7:0]               hz_cnt
);

  logic [NUM_RD*N-1:0] rd_wl_nxt;
  logic [N-1:0]        wr_wl_nxt;
  logic [NUM_RD-1:0]   byp_nxt;
  logic [NUM_RD-1:0]   rd_zero_nxt;
  logic                wr_drop_nxt;
  logic                wr_ok;
  logic [ADDR_W-1:0]   rd_sel;
  logic [8:0]          byp_pop;
  logic [9:0]          hz_sum;
  logic [7:0]          hz_nxt;

  always_comb begin
    rd_wl_nxt   = '0;
    wr_wl_nxt   = '0;
    byp_nxt     = '0;
    rd_zero_nxt = '0;
    wr_drop_nxt = 1'b0;
    rd_sel      = '0;
    byp_pop     = '0;
`ifdef ZERO_REG_EN
    // A write to register 0 is discarded, which also kills any bypass to id 0.
    wr_ok       = wr_en & (wr_id != '0);
    wr_drop_nxt = wr_en & (wr_id == '0);
`else
    wr_ok       = wr_en;
`endif
    for (int unsigned j = 0; j < N; j++) begin
      wr_wl_nxt[j] = wr_ok && (wr_id == ADDR_W'(j));
    end
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_sel = rd_id[i*ADDR_W +: ADDR_W];
      for (int unsigned j = 0; j < N; j++) begin
        rd_wl_nxt[i*N + j] = rd_en[i] && (rd_sel == ADDR_W'(j));
      end
      byp_nxt[i] = rd_en[i] && wr_ok && (rd_sel == wr_id);
`ifdef ZERO_REG_EN
      rd_zero_nxt[i] = rd_en[i] && (rd_sel == '0);
`endif
      byp_pop = byp_pop + 9'(byp_nxt[i]);
    end
    hz_sum = 10'(hz_cnt) + 10'(byp_pop);
    hz_nxt = (hz_sum > 10'd255) ? 8'hFF : hz_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_wl   <= '0;
      wr_wl   <= '0;
      byp     <= '0;
      rd_zero <= '0;
      wr_drop <= 1'b0;
      hz_cnt  <= '0;
    end else begin
      if (!stall) begin
        rd_wl   <= rd_wl_nxt;
        wr_wl   <= wr_wl_nxt;
        byp     <= byp_nxt;
        rd_zero <= rd_zero_nxt;
        wr_drop <= wr_drop_nxt;
      end
      if (cnt_clr) begin
        hz_cnt <= '0;
      end else if (!stall) begin
        hz_cnt <= hz_nxt;
      end
    end
  end

endmodule
